// File: rtl/boreal_cursor_sched.sv
// Update scheduler and source arbiter for the cursor velocity predictor.
// Issues one clamped velocity sample per TICK_DIV cycles from the decoder latch or the calibration source.
module boreal_cursor_sched #(
    parameter int unsigned        TICK_DIV    = 1000,
    parameter int unsigned        STALE_TICKS = 4,
    parameter logic signed [23:0] VMAX        = 24'sd2097151
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic signed [23:0] dec_vx_i,
    input  logic signed [23:0] dec_vy_i,
    input  logic               cal_req_i,
    output logic               cal_grant_o,
    input  logic signed [23:0] cal_vx_i,
    input  logic signed [23:0] cal_vy_i,
    output logic               pred_valid_o,
    output logic signed [23:0] pred_vx_o,
    output logic signed [23:0] pred_vy_o,
    output logic               pred_flush_o,
    output logic               stale_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        CAL   = 2'd3
    } state_e;

    localparam int unsigned        CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned        STALE_W   = $clog2(STALE_TICKS + 1);
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_TICKS);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic signed [23:0]   latch_vx_q, latch_vx_d;
    logic signed [23:0]   latch_vy_q, latch_vy_d;
    logic                 fresh_q, fresh_d;
    logic [STALE_W-1:0]   stale_cnt_q, stale_cnt_d;
    logic [STALE_W-1:0]   stale_cnt_inc;
    logic                 stale_q, stale_d;
    logic                 pred_valid_q, pred_valid_d;
    logic signed [23:0]   pred_vx_q, pred_vx_d;
    logic signed [23:0]   pred_vy_q, pred_vy_d;
    logic                 cal_grant_q, cal_grant_d;
    logic                 tick;
    logic                 dec_hs;

    function automatic logic signed [23:0] clamp(input logic signed [23:0] v);
        if (v > VMAX)       return VMAX;
        else if (v < -VMAX) return -VMAX;
        else                return v;
    endfunction

    assign dec_ready_o   = (state_q == RUN) || (state_q == CAL);
    assign dec_hs        = dec_valid_i && dec_ready_o;
    assign tick          = (tick_cnt_q == TICK_LAST);
    assign stale_cnt_inc = (stale_cnt_q == STALE_MAX) ? stale_cnt_q : stale_cnt_q + 1'b1;
    assign cal_grant_d   = (state_d == CAL);

    always_comb begin
        // NOTE: every _d takes its _q (or idle value) first so no path through the case infers a latch.
        state_d      = state_q;
        tick_cnt_d   = '0;
        latch_vx_d   = latch_vx_q;
        latch_vy_d   = latch_vy_q;
        fresh_d      = fresh_q;
        stale_cnt_d  = stale_cnt_q;
        stale_d      = stale_q;
        pred_valid_d = 1'b0;
        pred_vx_d    = pred_vx_q;
        pred_vy_d    = pred_vy_q;

        case (state_q)
            IDLE: begin
                if (enable_i) state_d = FLUSH;
            end
            FLUSH: begin
                fresh_d     = 1'b0;
                stale_cnt_d = '0;
                stale_d     = 1'b0;
                if (!enable_i)     state_d = IDLE;
                else if (cal_req_i) state_d = CAL;
                else               state_d = RUN;
            end
            RUN, CAL: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    stale_cnt_d = '0;
                end else if ((state_q == RUN && cal_req_i) || (state_q == CAL && !cal_req_i)) begin
                    // Source change outranks a coincident tick: nothing is issued this cycle.
                    state_d = FLUSH;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                    if (tick) begin
                        pred_valid_d = 1'b1;
                        if (state_q == CAL) begin
                            pred_vx_d = clamp(cal_vx_i);
                            pred_vy_d = clamp(cal_vy_i);
                        end else if (fresh_q) begin
                            pred_vx_d   = clamp(latch_vx_q);
                            pred_vy_d   = clamp(latch_vy_q);
                            fresh_d     = 1'b0;
                            stale_cnt_d = '0;
                            stale_d     = 1'b0;
                        end else begin
                            stale_cnt_d = stale_cnt_inc;
                            if (stale_cnt_inc == STALE_MAX) begin
                                pred_vx_d = '0;
                                pred_vy_d = '0;
                                stale_d   = 1'b1;
                            end else begin
                                pred_vx_d = clamp(latch_vx_q);
                                pred_vy_d = clamp(latch_vy_q);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A sample accepted on the tick cycle is kept fresh for the next tick.
        if (dec_hs) begin
            latch_vx_d = dec_vx_i;
            latch_vy_d = dec_vy_i;
            fresh_d    = 1'b1;
        end
    end

    // NOTE: synchronous reset clears every register, sample latch included; all state updates are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            latch_vx_q   <= '0;
            latch_vy_q   <= '0;
            fresh_q      <= 1'b0;
            stale_cnt_q  <= '0;
            stale_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_vx_q    <= '0;
            pred_vy_q    <= '0;
            cal_grant_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            latch_vx_q   <= latch_vx_d;
            latch_vy_q   <= latch_vy_d;
            fresh_q      <= fresh_d;
            stale_cnt_q  <= stale_cnt_d;
            stale_q      <= stale_d;
            pred_valid_q <= pred_valid_d;
            pred_vx_q    <= pred_vx_d;
            pred_vy_q    <= pred_vy_d;
            cal_grant_q  <= cal_grant_d;
        end
    end

    assign cal_grant_o  = cal_grant_q;
    assign pred_valid_o = pred_valid_q;
    assign pred_vx_o    = pred_vx_q;
    assign pred_vy_o    = pred_vy_q;
    assign pred_flush_o = (state_q == FLUSH);
    assign stale_o      = stale_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_boreal_cursor_sched.sv
// Randomised bench for boreal_cursor_sched: a period-level reference model queues expected
// issues; a negedge monitor pops and compares them and checks control outputs every cycle.
module tb_boreal_cursor_sched;

    localparam int TICK_DIV    = 8;
    localparam int STALE_TICKS = 3;
    localparam int VMAX_I      = 2000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               dec_valid = 1'b0;
    logic               cal_req = 1'b0;
    logic signed [23:0] dec_vx = '0, dec_vy = '0, cal_vx = '0, cal_vy = '0;
    logic               dec_ready, cal_grant, pred_valid, pred_flush, stale;
    logic signed [23:0] pred_vx, pred_vy;
    logic [1:0]         state;

    boreal_cursor_sched #(
        .TICK_DIV   (TICK_DIV),
        .STALE_TICKS(STALE_TICKS),
        .VMAX       (24'sd2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .dec_valid_i (dec_valid),
        .dec_ready_o (dec_ready),
        .dec_vx_i    (dec_vx),
        .dec_vy_i    (dec_vy),
        .cal_req_i   (cal_req),
        .cal_grant_o (cal_grant),
        .cal_vx_i    (cal_vx),
        .cal_vy_i    (cal_vy),
        .pred_valid_o(pred_valid),
        .pred_vx_o   (pred_vx),
        .pred_vy_o   (pred_vy),
        .pred_flush_o(pred_flush),
        .stale_o     (stale),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int vx;
        int vy;
    } issue_t;

    issue_t exp_q[$];
    int     m_mode = 0;       // 0 idle, 1 flush, 2 decoder, 3 calibration
    int     m_next = 0;
    int     m_run_len = 0;    // cycles spent in the current active stretch
    int     m_last_vx = 0, m_last_vy = 0;
    int     m_idle_ticks = 0; // ticks since the last fresh decoder sample was issued
    int     m_hold_vx = 0, m_hold_vy = 0;
    bit     m_pending = 0;
    bit     m_stale = 0;
    bit     m_accept = 0;

    function automatic int clamp_ref(input int v);
        if (v > VMAX_I)  return VMAX_I;
        if (v < -VMAX_I) return -VMAX_I;
        return v;
    endfunction

    task automatic m_issue(input int vx, input int vy);
        issue_t e;
        e.vx = vx;
        e.vy = vy;
        exp_q.push_back(e);
        m_hold_vx = vx;
        m_hold_vy = vy;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_run_len = 0; m_last_vx = 0; m_last_vy = 0;
            m_idle_ticks = 0; m_pending = 0; m_stale = 0;
            m_hold_vx = 0; m_hold_vy = 0;
            exp_q.delete();
        end else begin
            m_accept = dec_valid && (m_mode >= 2);
            m_next   = m_mode;
            if (m_mode == 1) begin
                m_pending = 0; m_idle_ticks = 0; m_stale = 0;
            end
            if (m_mode == 0) begin
                if (enable) m_next = 1;
            end else if (!enable) begin
                m_next = 0;
            end else if (m_mode == 1) begin
                m_next = cal_req ? 3 : 2;
            end else if ((m_mode == 2 && cal_req) || (m_mode == 3 && !cal_req)) begin
                m_next = 1;
            end else begin
                m_run_len++;
                if (m_run_len % TICK_DIV == 0) begin
                    if (m_mode == 3) begin
                        m_issue(clamp_ref(int'(cal_vx)), clamp_ref(int'(cal_vy)));
                    end else if (m_pending) begin
                        m_pending = 0; m_idle_ticks = 0; m_stale = 0;
                        m_issue(clamp_ref(m_last_vx), clamp_ref(m_last_vy));
                    end else begin
                        m_idle_ticks++;
                        if (m_idle_ticks >= STALE_TICKS) begin
                            m_stale = 1;
                            m_issue(0, 0);
                        end else begin
                            m_issue(clamp_ref(m_last_vx), clamp_ref(m_last_vy));
                        end
                    end
                end
            end
            if (m_next != m_mode) m_run_len = 0;
            if (m_accept) begin
                m_last_vx = int'(dec_vx);
                m_last_vy = int'(dec_vy);
                m_pending = 1;
            end
            m_mode = m_next;
        end
    end

    // ---------------- monitor ----------------
    issue_t mon_e;

    always @(negedge clk) begin
        check("ctrl{state,grant,flush,ready}",
              int'({state, cal_grant, pred_flush, dec_ready}),
              int'({m_mode[1:0], m_mode == 3, m_mode == 1, m_mode >= 2}));
        check("stale", int'(stale), int'(m_stale));
        check("pred_valid", int'(pred_valid), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (pred_valid) begin
                check("issue_vx", int'(pred_vx), mon_e.vx);
                check("issue_vy", int'(pred_vy), mon_e.vy);
            end
        end else begin
            check("hold_vx", int'(pred_vx), m_hold_vx);
            check("hold_vy", int'(pred_vy), m_hold_vy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int vx, input int vy);
        @(negedge clk);
        dec_valid = 1'b1;
        dec_vx    = 24'(vx);
        dec_vy    = 24'(vy);
        @(negedge clk);
        dec_valid = 1'b0;
    endtask

    function automatic int rnd_small();
        return int'($urandom_range(0, 6000)) - 3000;
    endfunction

    initial begin
        int                 waited;
        logic signed [23:0] rv_x, rv_y;

        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);

        // Enable and steady decoder stream.
        enable = 1'b1;
        repeat (6) begin
            send(1000, -500);
            cycles(TICK_DIV - 2);
        end
        repeat (6) begin
            send(rnd_small(), rnd_small());
            cycles(TICK_DIV - 2);
        end

        // Stale decay then recovery.
        send(1000, 1000);
        cycles(6 * TICK_DIV);
        send(200, -200);
        cycles(2 * TICK_DIV);

        // Clamp boundaries and full-range values.
        send(5000, -5000);   cycles(TICK_DIV);
        send(2000, -2000);   cycles(TICK_DIV);
        send(-2000, 2000);   cycles(TICK_DIV);
        send(2001, -2001);   cycles(TICK_DIV);
        repeat (6) begin
            rv_x = 24'($urandom);
            rv_y = 24'($urandom);
            send(int'(rv_x), int'(rv_y));
            cycles(TICK_DIV);
        end

        // Calibration handover and return.
        cycles(3);
        cal_vx  = 24'sd42;
        cal_vy  = -24'sd42;
        cal_req = 1'b1;
        cycles(3 * TICK_DIV);
        send(777, -777);
        cycles(TICK_DIV);
        cal_vx = 24'sd5000;
        cal_vy = -24'sd9000;
        cycles(2 * TICK_DIV);
        cal_req = 1'b0;
        cycles(3 * TICK_DIV);

        // Handshake aligned onto the tick cycle.
        repeat (3) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!pred_valid && waited < 4 * TICK_DIV);
            check("pred_valid_wait", int'(pred_valid), 1);
            cycles(TICK_DIV - 2);
            send(rnd_small(), rnd_small());
            cycles(2 * TICK_DIV);
        end

        // Random soak with source toggles.
        repeat (400) begin
            @(negedge clk);
            dec_valid = ($urandom_range(0, 3) == 0);
            dec_vx    = 24'(rnd_small());
            dec_vy    = 24'(rnd_small());
            cal_vx    = 24'(rnd_small());
            cal_vy    = 24'(rnd_small());
            if ($urandom_range(0, 79) == 0) cal_req = ~cal_req;
        end
        @(negedge clk);
        dec_valid = 1'b0;
        cal_req   = 1'b0;
        cycles(3 * TICK_DIV);

        // Abort mid-period, then re-enable and reset mid-run.
        cycles(3);
        enable = 1'b0;
        cycles(3 * TICK_DIV);
        enable = 1'b1;
        send(321, -321);
        cycles(2 * TICK_DIV + 4);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(4);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boreal_cursor_sched.md
# boreal_cursor_sched

Update scheduler and source arbiter for the cursor velocity predictor. It accepts asynchronous-rate velocity samples from the neural decoder and a calibration/override source, and issues exactly one clamped velocity sample per fixed update period to the predictor. It flushes the predictor's history whenever the source changes, and drives decayed or zero velocity when decoder samples go stale. Sits between the decoder output and the predictor input in the cursor path.

## Interface
- TICK_DIV, 1000: clk cycles per update period (>=4)
- STALE_TICKS, 4: consecutive ticks without a fresh decoder sample before output forced to zero (>=1)
- VMAX, 24'sd2097151: symmetric clamp magnitude for issued velocity
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduler run enable
- dec_valid  in  1  decoder sample valid
- dec_ready  out  1  scheduler can accept decoder sample
- dec_vx, dec_vy  in  24 signed  decoder velocity
- cal_req  in  1  calibration source requests ownership (level)
- cal_grant  out  1  calibration source owns the path
- cal_vx, cal_vy  in  24 signed  calibration velocity, sampled on tick
- pred_valid  out  1  one-cycle strobe to predictor
- pred_vx, pred_vy  out  24 signed  velocity to predictor
- pred_flush  out  1  one-cycle pulse to predictor reset
- stale  out  1  decoder stream considered stale
- state  out  2  IDLE=0, FLUSH=1, RUN=2, CAL=3

## Operation
- Reset: state IDLE; all outputs 0; tick counter 0; latch, fresh flag, stale counter cleared.
- Tick counter counts 0..TICK_DIV-1 in RUN and CAL only; tick = (count==TICK_DIV-1), then wraps to 0. Held at 0 in IDLE and FLUSH.
- dec_ready = 1 in RUN and CAL, 0 in IDLE and FLUSH. Handshake occurs when dec_valid && dec_ready. It loads the latch and sets fresh. In CAL, decoder samples are accepted and latched but not issued.
- IDLE: enable=1 -> FLUSH.
- FLUSH: pred_flush=1 for exactly this one cycle. Next state is CAL if cal_req=1, else RUN. Clears fresh, stale counter, and stale.
- RUN, on tick:
  - fresh=1: issue latch, clear fresh, stale counter=0, stale=0.
  - fresh=0: increment stale counter (saturating).
    - If the counter reaches STALE_TICKS: issue 0 and set stale.
    - Otherwise: re-issue the last latch value.
- RUN: cal_req=1 -> FLUSH. Evaluated before the tick; the flush wins and no sample is issued that cycle.
- CAL: cal_grant=1. On tick, issue clamp(cal_vx, cal_vy). cal_req=0 -> FLUSH, then RUN.
- enable=0 in any state other than IDLE: -> IDLE next cycle. No pred_valid, no flush, counters cleared.
- Clamp: each axis is saturated independently to [-VMAX, +VMAX]. Inputs outside the range yield ±VMAX exactly.
- Simultaneous handshake and tick: the tick issues the prior latch contents. The new sample is latched with fresh=1 for the next tick; the set of fresh wins over the clear.

## Timing
- Tick in cycle N -> pred_valid=1 in cycle N+1 with pred_vx/pred_vy valid. pred_vx/pred_vy hold their value between strobes.
- First issue after FLUSH exits in cycle F: tick at F+TICK_DIV, pred_valid at F+TICK_DIV+1.
- pred_valid spacing in steady RUN/CAL: exactly TICK_DIV cycles.
- pred_flush never coincides with pred_valid.
- cal_grant is registered: it rises the cycle the state enters CAL and falls the cycle the state leaves CAL.
- stale updates in the same cycle pred_valid asserts.
- rst has priority over all inputs in the cycle it is sampled.

## Test plan
- Reset/enable, TICK_DIV=8: rst, then enable=1 -> state 1 with pred_flush pulse for 1 cycle, then state 2; first pred_valid exactly 9 cycles after leaving FLUSH; all outputs 0 before it.
- Steady decoder: one dec sample (vx=1000, vy=-500) per period -> each pred_valid carries the matching latched value; spacing 8 cycles; stale=0.
- Stale decay, STALE_TICKS=3: one sample of 1000, then silence -> issued values 1000, 1000, 1000, then 0 with stale=1. A new sample of 200 -> next issue 200, stale=0.
- Clamp, VMAX=100: dec_vx=5000, dec_vy=-5000 -> issued 100/-100. Sample exactly ±100 passes unchanged.
- Calibration handover: assert cal_req mid-period -> FLUSH pulse, no issue that cycle, cal_grant=1, cal_vx=42 issued on ticks. Drop cal_req -> second flush, back to RUN issuing the decoder latch.
- Collision and abort: dec handshake on the tick cycle -> old value issued, new value issued next tick. enable=0 mid-period -> IDLE next cycle, no further pred_valid.
